// File: rtl/fifo_accumulator.sv
// Burst accumulator: drains len words from an upstream FIFO
// with 1-cycle read latency and presents their sum via valid/ready.
module fifo_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 ck,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        OUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] issued_q;
    logic [LEN_WIDTH-1:0] accepted_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 rd_q;
    logic                 last_issue;
    logic                 last_accept;

    assign acc_d       = acc_q + ACC_WIDTH'(fifo_data);
    assign last_issue  = fifo_read &&
                         (issued_q + LEN_WIDTH'(1) == len_q);
    assign last_accept = rd_q &&
                         (accepted_q + LEN_WIDTH'(1) == len_q);

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? OUT : DRAIN;
                end
            end
            DRAIN: begin
                if (last_issue) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (last_accept) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_read = (state_q == DRAIN) && !fifo_empty &&
                    (issued_q < len_q);
        busy      = (state_q != IDLE);
    end

    // Data captured on rd_q belongs to the strobe of the previous cycle
    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            acc_q      <= '0;
            rd_q       <= 1'b0;
            sum        <= '0;
            sum_valid  <= 1'b0;
        end else begin
            rd_q <= fifo_read;
            if (fifo_read) begin
                issued_q <= issued_q + LEN_WIDTH'(1);
            end
            if (rd_q) begin
                acc_q      <= acc_d;
                accepted_q <= accepted_q + LEN_WIDTH'(1);
            end
            if (state_q == IDLE && start) begin
                len_q      <= len;
                issued_q   <= '0;
                accepted_q <= '0;
                acc_q      <= '0;
                if (len == '0) begin
                    sum       <= '0;
                    sum_valid <= 1'b1;
                end
            end
            if (state_q == FLUSH && last_accept) begin
                sum       <= acc_d;
                sum_valid <= 1'b1;
            end
            if (state_q == OUT && sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_accumulator.sv
// Scoreboard bench for fifo_accumulator: 40-bit and 32-bit
// accumulator instances share one FIFO model and stimulus.
module tb_fifo_accumulator;

    localparam int W  = 32;
    localparam int LW = 16;

    logic          ck = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          sum_ready = 1'b1;
    logic [LW-1:0] len = '0;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data = '0;
    logic          fifo_read;
    logic          fifo_read32;
    logic          sum_valid;
    logic          sum_valid32;
    logic          busy;
    logic          busy32;
    logic [39:0]   sum;
    logic [31:0]   sum32;

    typedef struct {
        logic [39:0] s40;
        logic [31:0] s32;
        int          lat;
    } exp_t;

    exp_t         exq[$];
    logic [W-1:0] fq[$];
    int           head = 0;
    logic         flush_req = 1'b0;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           rd_cnt = 0;
    int           rd_base = 0;
    logic         sv_prev = 1'b0;

    fifo_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(LW)) dut (
        .ck(ck), .reset(reset), .start(start), .len(len),
        .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .fifo_data(fifo_data), .sum(sum), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .busy(busy)
    );

    fifo_accumulator #(.WIDTH(32), .ACC_WIDTH(32), .LEN_WIDTH(LW)) dut32 (
        .ck(ck), .reset(reset), .start(start), .len(len),
        .fifo_empty(fifo_empty), .fifo_read(fifo_read32),
        .fifo_data(fifo_data), .sum(sum32), .sum_valid(sum_valid32),
        .sum_ready(sum_ready), .busy(busy32)
    );

    always #5 ck = ~ck;

    assign fifo_empty = (head >= fq.size());

    // FIFO model: dataout valid the cycle after the strobe
    always @(posedge ck) begin
        cyc++;
        if (fifo_read) rd_cnt++;
        if (flush_req) begin
            head <= fq.size();
        end else if (fifo_read) begin
            fifo_data <= fq[head];
            head <= head + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge ck) begin
        if (reset) begin
            chk("read_while_empty", 64'(fifo_read && fifo_empty), 0);
            chk("read_match_32", 64'(fifo_read32), 64'(fifo_read));
            if (sum_valid && !sv_prev) begin
                if (exq.size() == 0) begin
                    chk("unexpected_sum", 64'(sum), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exq.pop_front();
                    chk("sum40", 64'(sum), 64'(e.s40));
                    chk("sum32", 64'(sum32), 64'(e.s32));
                    chk("valid32", 64'(sum_valid32), 1);
                    if (e.lat >= 0)
                        chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
                end
            end
        end
        sv_prev = sum_valid;
    end

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
    endtask

    task automatic burst(input int n, input bit expect_sum,
                         input logic [39:0] e40, input logic [31:0] e32,
                         input int lat);
        @(negedge ck);
        if (expect_sum) exq.push_back('{e40, e32, lat});
        rd_base = rd_cnt;
        start = 1'b1;
        len = LW'(n);
        @(posedge ck);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge ck);
        while (busy && n < 200) begin
            @(negedge ck);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, need idle", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge ck);
        chk("rst_sum", 64'(sum), 0);
        chk("rst_valid", 64'(sum_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_read", 64'(fifo_read), 0);
        reset = 1'b1;

        // Four words, sustained reads
        push(1); push(2); push(3); push(4);
        burst(4, 1, 40'd10, 32'd10, 5);
        wait_idle("t_basic");
        chk("t_basic_reads", 64'(rd_cnt - rd_base), 4);

        // Zero-length burst
        burst(0, 1, 40'd0, 32'd0, 0);
        @(negedge ck);
        chk("t_len0_busy", 64'(busy), 1);
        chk("t_len0_valid", 64'(sum_valid), 1);
        @(negedge ck);
        chk("t_len0_busy_after", 64'(busy), 0);
        chk("t_len0_valid_after", 64'(sum_valid), 0);
        chk("t_len0_reads", 64'(rd_cnt - rd_base), 0);

        // FIFO runs dry mid-burst
        push(5);
        burst(3, 1, 40'd18, 32'd18, -1);
        repeat (5) @(negedge ck);
        chk("t_stall_reads_mid", 64'(rd_cnt - rd_base), 1);
        chk("t_stall_busy", 64'(busy), 1);
        push(6); push(7);
        wait_idle("t_stall");
        chk("t_stall_reads", 64'(rd_cnt - rd_base), 3);

        // Wrap in the 32-bit instance
        push(32'hFFFF_FFFF); push(32'h2);
        burst(2, 1, 40'h1_0000_0001, 32'h1, 3);
        wait_idle("t_wrap");

        // Back-pressure in OUT, start ignored
        sum_ready = 1'b0;
        push(3); push(4);
        burst(2, 1, 40'd7, 32'd7, 3);
        begin
            int n = 0;
            while (!sum_valid && n < 50) begin
                @(negedge ck);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            start = (i == 3 || i == 4);
            len = 16'd5;
            @(negedge ck);
            chk("t_hold_sum", 64'(sum), 7);
            chk("t_hold_valid", 64'(sum_valid), 1);
            chk("t_hold_busy", 64'(busy), 1);
        end
        start = 1'b1;
        sum_ready = 1'b1;
        @(negedge ck);
        start = 1'b0;
        chk("t_release_busy", 64'(busy), 0);
        chk("t_release_valid", 64'(sum_valid), 0);
        @(negedge ck);
        chk("t_release_no_start", 64'(busy), 0);

        // Reset mid-burst, then a fresh burst
        push(1); push(2); push(3); push(4);
        burst(4, 0, 40'd0, 32'd0, -1);
        begin
            int n = 0;
            while ((rd_cnt - rd_base) < 2 && n < 50) begin
                @(negedge ck);
                n++;
            end
        end
        chk("t_rst_reads_before", 64'(rd_cnt - rd_base), 2);
        reset = 1'b0;
        #1;
        chk("t_rst_read", 64'(fifo_read), 0);
        chk("t_rst_busy", 64'(busy), 0);
        chk("t_rst_valid", 64'(sum_valid), 0);
        chk("t_rst_sum", 64'(sum), 0);
        chk("t_rst_sum32", 64'(sum32), 0);
        @(negedge ck);
        flush_req = 1'b1;
        @(negedge ck);
        flush_req = 1'b0;
        reset = 1'b1;
        push(8); push(9);
        burst(2, 1, 40'd17, 32'd17, 3);
        wait_idle("t_after_rst");
        chk("t_after_rst_reads", 64'(rd_cnt - rd_base), 2);

        repeat (2) @(negedge ck);
        chk("scoreboard_drained", 64'(exq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
